hilo_mul_scheduler: RTL and testbench
=====================================

# hilo_mul_scheduler

Sequencing controller for the multi-cycle unsigned multiplier and the Hi/Lo register pair inside the EX-stage arithmetic unit. It decodes the instruction in EX, launches MULTU, drives the multiplier run enable for a fixed number of cycles and pulses the Hi/Lo write. It also produces the pipeline interlock: MFHI, MFLO or a second MULTU stall while a multiply is in flight. Unrelated ALU and shift instructions keep flowing and overlap the multiply.

## Interface
- MUL_CYCLES, 32: multiplier iteration count, from operand load to product valid; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_aluop  in  2  ALUop of the EX instruction; 2'b10 = R-type.
- ex_funct  in  6  funct field of the EX instruction.
- mul_start  out  1  operand-load pulse to the multiplier.
- mul_run  out  1  multiplier iteration enable.
- hilo_we  out  1  one-cycle write of the 64-bit product into Hi/Lo.
- busy  out  1  a multiply is in flight (state != IDLE).
- stall  out  1  freeze IF/ID/EX; the EX instruction is re-presented next cycle.

## Operation
- Decode is qualified by ex_valid & (ex_aluop == 2'b10):
  - is_mul: funct 6'd25 (MULTU).
  - is_mfhi: funct 6'd16.
  - is_mflo: funct 6'd18.
  - Any other ALUop with a matching funct is ignored.
- FSM states are IDLE, RUN and WB.
- IDLE:
  - is_mul drives mul_start=1 combinationally in the same cycle; the multiplier latches its operands at the closing edge.
  - The state moves to RUN and cnt loads MUL_CYCLES-1.
  - No stall is raised in IDLE.
- RUN:
  - mul_run=1.
  - cnt decrements each cycle; at cnt==0 the state moves to WB.
- WB:
  - hilo_we=1 for exactly one cycle; the state moves to IDLE.
- Counter width is ceil(log2(MUL_CYCLES)), minimum 1 bit.
- stall = busy & (is_mul | is_mfhi | is_mflo), combinational.
  - WB is included in the stall condition because the Hi/Lo write lands at the end of WB.
- mul_start is never asserted when state != IDLE. A stalled MULTU is accepted in the first IDLE cycle it is presented.
- mul_start, mul_run and hilo_we are mutually exclusive in every cycle.
- Reset:
  - rst=0 forces state=IDLE and cnt=0 asynchronously.
  - mul_run, hilo_we and busy go to 0 immediately.
  - mul_start and stall are 0 while rst=0.
  - An in-flight multiply is abandoned: there is no hilo_we, and Hi/Lo keep their prior contents.
- ex_valid=0 means no decode, no start and no stall, even while busy.

## Timing
- MULTU accepted at cycle T:
  - mul_start at T.
  - mul_run during T+1 .. T+MUL_CYCLES.
  - hilo_we at T+MUL_CYCLES+1.
  - busy during T+1 .. T+MUL_CYCLES+1.
  - Back in IDLE at T+MUL_CYCLES+2.
- MFHI/MFLO presented at any cycle in T+1 .. T+MUL_CYCLES+1 stalls through T+MUL_CYCLES+1. It proceeds at T+MUL_CYCLES+2 and reads the new product.
- A second MULTU stalls the same way and is accepted at T+MUL_CYCLES+2 with mul_start there.
  - Minimum MULTU-to-MULTU spacing is MUL_CYCLES+2.
- Release of rst is synchronous in effect: the first decode happens on the first rising edge with rst=1.

## Test plan
- Reset: drive rst=0 with MULTU presented -> mul_start, mul_run, hilo_we, busy and stall all 0; after release, MULTU at cycle 0 gives mul_start=1 at cycle 0.
- Single multiply, MUL_CYCLES=32, MULTU at cycle 0 then ADD (funct 32) -> mul_run=1 on cycles 1..32 (32 cycles), hilo_we=1 only at cycle 33, busy 1..33, stall never asserted.
- MFHI at cycle 5 after MULTU at 0 -> stall=1 on cycles 5..33, 0 at 34; hilo_we at 33 precedes the read.
- Back-to-back: MULTU at 0, MULTU at 1 -> stall on 1..33, second mul_start at 34, second hilo_we at 67.
- Mid-flight reset: MULTU at 0, rst=0 asynchronously at cycle 10 -> mul_run and busy drop in the same cycle, and hilo_we never pulses. After release, MFLO is presented with stall=0.
- Decode gating: ex_aluop=2'b00 with funct=25, and ex_valid=0 with MULTU -> no mul_start; MFHI with ex_valid=0 during RUN -> stall=0.

Source files
------------

// File: rtl/hilo_mul_scheduler.sv
// Sequencing controller for the multi-cycle unsigned multiplier and Hi/Lo write,
// plus the EX-stage interlock for MFHI/MFLO/MULTU while a multiply is in flight.
module hilo_mul_scheduler #(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [1:0] ex_aluop,
  input  logic [5:0] ex_funct,
  output logic       mul_start,
  output logic       mul_run,
  output logic       hilo_we,
  output logic       busy,
  output logic       stall
);

  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            rtype, is_mul, is_mfhi, is_mflo;

  assign rtype   = ex_valid & (ex_aluop == 2'b10);
  assign is_mul  = rtype & (ex_funct == 6'd25);
  assign is_mfhi = rtype & (ex_funct == 6'd16);
  assign is_mflo = rtype & (ex_funct == 6'd18);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // mul_start is gated by rst so no operand load is signalled while held in reset.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mul_start  = 1'b0;
    mul_run    = 1'b0;
    hilo_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_mul && rst) begin
          mul_start  = 1'b1;
          state_next = RUN;
          cnt_next   = CW'(MUL_CYCLES - 1);
        end
      end
      RUN: begin
        mul_run = 1'b1;
        if (cnt_reg == '0) begin
          state_next = WB;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      WB: begin
        hilo_we    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // WB still stalls readers: the product only lands in Hi/Lo at the end of WB.
  assign busy  = (state_reg != IDLE);
  assign stall = busy & (is_mul | is_mfhi | is_mflo);

endmodule

// File: tb/tb_hilo_mul_scheduler.sv
// Self-checking bench for hilo_mul_scheduler: directed scenarios plus random
// instruction streams, checked against a timeline model of the multiply.
module tb_hilo_mul_scheduler;

  localparam int M = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ex_valid = 1'b0;
  logic [1:0] ex_aluop = 2'b00;
  logic [5:0] ex_funct = 6'd0;
  logic       mul_start, mul_run, hilo_we, busy, stall;

  hilo_mul_scheduler #(.MUL_CYCLES(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_aluop  (ex_aluop),
    .ex_funct  (ex_funct),
    .mul_start (mul_start),
    .mul_run   (mul_run),
    .hilo_we   (hilo_we),
    .busy      (busy),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_t  = -1000;  // cycle at which the in-flight multiply was accepted

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check just after, advance the model at posedge.
  task automatic step(input logic v, input logic [1:0] a, input logic [5:0] f, input logic r);
    int   age;
    logic dec, e_mul, e_any, e_busy, e_run, e_we, e_start, e_stall;
    @(negedge clk);
    ex_valid = v;
    ex_aluop = a;
    ex_funct = f;
    rst      = r;
    #1;
    if (!r) start_t = -1000;
    age     = cyc - start_t;
    e_busy  = r && (age >= 1) && (age <= M + 1);
    e_run   = r && (age >= 1) && (age <= M);
    e_we    = r && (age == M + 1);
    dec     = v && (a == 2'b10);
    e_mul   = dec && (f == 6'd25);
    e_any   = dec && (f == 6'd25 || f == 6'd16 || f == 6'd18);
    e_start = r && e_mul && !e_busy;
    e_stall = e_busy && e_any;
    $display("cyc=%0d rst=%0b v=%0b op=%0d f=%0d -> start=%0b run=%0b we=%0b busy=%0b stall=%0b",
             cyc, r, v, a, f, mul_start, mul_run, hilo_we, busy, stall);
    check_eq("mul_start", 32'(mul_start), 32'(e_start));
    check_eq("mul_run",   32'(mul_run),   32'(e_run));
    check_eq("hilo_we",   32'(hilo_we),   32'(e_we));
    check_eq("busy",      32'(busy),      32'(e_busy));
    check_eq("stall",     32'(stall),     32'(e_stall));
    @(posedge clk);
    if (e_start) start_t = cyc;
    cyc++;
  endtask

  task automatic steps(input int n, input logic v, input logic [1:0] a, input logic [5:0] f);
    for (int i = 0; i < n; i++) step(v, a, f, 1'b1);
  endtask

  initial begin
    logic [5:0] picks [5];
    picks[0] = 6'd25; picks[1] = 6'd16; picks[2] = 6'd18; picks[3] = 6'd32; picks[4] = 6'd0;

    // Reset held with MULTU presented, then MULTU accepted on release.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 6'd25, 1'b0);
    step(1'b1, 2'b10, 6'd25, 1'b1);
    steps(40, 1'b1, 2'b10, 6'd32);

    // MFHI five cycles after MULTU, re-presented while stalled.
    step(1'b1, 2'b10, 6'd25, 1'b1);
    steps(4, 1'b1, 2'b10, 6'd32);
    steps(31, 1'b1, 2'b10, 6'd16);
    steps(3, 1'b1, 2'b10, 6'd32);

    // Back-to-back MULTU.
    step(1'b1, 2'b10, 6'd25, 1'b1);
    steps(34, 1'b1, 2'b10, 6'd25);
    steps(40, 1'b1, 2'b10, 6'd32);

    // Mid-flight reset, then MFLO after release.
    step(1'b1, 2'b10, 6'd25, 1'b1);
    steps(9, 1'b1, 2'b10, 6'd32);
    step(1'b1, 2'b10, 6'd32, 1'b0);
    step(1'b1, 2'b10, 6'd32, 1'b0);
    steps(40, 1'b1, 2'b10, 6'd18);

    // Decode gating.
    steps(3, 1'b1, 2'b00, 6'd25);
    steps(3, 1'b0, 2'b10, 6'd25);
    step(1'b1, 2'b10, 6'd25, 1'b1);
    steps(10, 1'b0, 2'b10, 6'd16);
    steps(10, 1'b1, 2'b01, 6'd18);
    steps(20, 1'b1, 2'b10, 6'd32);

    // Random instruction stream with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      logic       v, r;
      logic [1:0] a;
      logic [5:0] f;
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 4) != 0) ? picks[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      r = ($urandom_range(0, 199) != 0);
      step(v, a, f, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
